mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the single unified memory port between the fetch stage (instruction reads) and the memory stage (lw/sw data accesses) of the 5-stage pipeline. Each transaction is latched into the block and held on the memory port until the memory acknowledges it. The completion is then returned to the owning requester, and per-requester stall signals are raised for the hazard logic. Data accesses have fixed priority. Misaligned word accesses are rejected locally, and cycles where fetch loses arbitration are counted.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; must be 32.
- `CNT_W`, 16, width of the contention counter.

Ports:
- `clk_i`  in  1  clock; all state on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `if_req_i`  in  1  fetch request; held with `if_addr_i` until `if_ack_o`.
- `if_addr_i`  in  `ADDR_W`  fetch address.
- `if_ack_o`  out  1  one-cycle fetch completion pulse.
- `if_rdata_o`  out  `DATA_W`  fetched instruction; valid when `if_ack_o` is high.
- `dm_req_i`  in  1  data request; held with its qualifiers until `dm_ack_o`.
- `dm_we_i`  in  1  1 = store (sw), 0 = load (lw).
- `dm_addr_i`  in  `ADDR_W`  data address.
- `dm_wdata_i`  in  `DATA_W`  store data.
- `dm_ack_o`  out  1  one-cycle data completion pulse.
- `dm_err_o`  out  1  high together with `dm_ack_o` when the access was misaligned.
- `dm_rdata_o`  out  `DATA_W`  load data; valid when `dm_ack_o` is high and `dm_err_o` is low.
- `mem_req_o`  out  1  memory request; held until `mem_ready_i`.
- `mem_we_o`  out  1  memory write enable.
- `mem_addr_o`  out  `ADDR_W`  memory address.
- `mem_wdata_o`  out  `DATA_W`  memory write data.
- `mem_rdata_i`  in  `DATA_W`  memory read data; sampled when `mem_ready_i` is high.
- `mem_ready_i`  in  1  memory completion; accepted only while `mem_req_o` is high.
- `stall_f_o`  out  1  fetch stall to the hazard logic.
- `stall_m_o`  out  1  memory-stage stall to the hazard logic.
- `conflict_cnt_o`  out  `CNT_W`  saturating count of contention cycles.

## Operation
States: `IDLE`, `BUSY_I`, `BUSY_D`, `DONE`.

- **IDLE, grant decision.** Each requester is eligible when its request is high and its ack is not high in the current cycle.
  - Data is eligible, address aligned (`dm_addr_i[1:0]==0`): latch addr/we/wdata into the port registers and go to `BUSY_D`.
  - Data is eligible, address misaligned: no memory access; go to `DONE` with the error flag set.
  - Otherwise, fetch is eligible: latch `if_addr_i` and go to `BUSY_I`. Fetch addresses are not alignment-checked.
  - Data always wins when both requesters are eligible.
- **BUSY_I / BUSY_D.**
  - `mem_req_o` is 1 and the port registers are stable.
  - On `mem_ready_i`=1: capture `mem_rdata_i` into the owner's rdata register (loads and fetches only; stores leave `dm_rdata_o` unchanged), then go to `DONE`.
- **DONE.**
  - Pulse the owner's ack (plus `dm_err_o` if flagged) for exactly one cycle.
  - Return to `IDLE`.
- **Stalls.**
  - `stall_f_o = if_req_i & ~if_ack_o`; `stall_m_o = dm_req_i & ~dm_ack_o`.
  - Both are combinational from inputs and registered acks.
- **Contention counter.**
  - Increments in every cycle where `if_req_i`=1 and the port is owned by, or being granted to, data.
  - Saturates at all-ones; never wraps.
- **Reset values.**
  - All outputs are 0, including rdata registers and the counter.
  - State returns to `IDLE`.
  - A transaction in flight when reset is applied is abandoned: `mem_req_o` drops on the next edge, no ack is issued, and a late `mem_ready_i` is ignored.

## Timing
- Request-to-ack latency (zero-wait memory): request sampled in `IDLE` at cycle t; `mem_req_o` high at t+1; `mem_ready_i` high at t+1; ack at t+2.
- Each memory wait cycle adds one cycle of latency.
- Misaligned data access: ack plus err at t+1; `mem_req_o` never asserts.
- Back-to-back transactions: the next grant is decided in the `IDLE` cycle that follows `DONE`. Port throughput is therefore at most one transaction per 3 cycles.
- Requests and addresses changing while the port is busy have no effect on the port registers.
- `mem_ready_i` while not busy is ignored.

## Structure
- Package `mem_arb_pkg` holds:
  - state enum `arb_state_t`;
  - owner enum `arb_owner_t` {`OWN_I`, `OWN_D`};
  - default width constants.
- Single module with no sub-modules: one state register, one port register set, two rdata registers, and the counter.

## Test plan
- **Single fetch.** `if_req`, addr 0x100; memory returns 0x00500093 with zero wait. Required: `if_ack` at t+2 with `if_rdata`=0x00500093; `stall_f` high for t..t+1.
- **Simultaneous requests.** `if_req` at 0x104 and `dm_req` lw at 0x2000 in the same cycle. Required: data transaction first, fetch granted in the `IDLE` cycle after `dm_ack`; `conflict_cnt` incremented by 3.
- **Store with 2 wait cycles.** sw 0xDEADBEEF to 0x2004. Required: `mem_we`=1, `mem_wdata`=0xDEADBEEF held for 3 cycles; `dm_ack` at t+4; `dm_rdata` unchanged.
- **Misaligned load.** lw at 0x2002. Required: `dm_ack`=`dm_err`=1 at t+1; no `mem_req`.
- **Reset mid-transaction.** `rst_i` asserted while in `BUSY_D`. Required: all outputs 0 the next cycle; a late `mem_ready` produces no ack.
- **Counter saturation.** Hold `if_req` under continuous data traffic with the counter preloaded near max. Required: `conflict_cnt` stops at 0xFFFF and does not wrap.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  // Word accesses must have the two low address bits clear.
  function automatic logic word_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Fixed-priority arbiter sharing one memory port between fetch and data accesses,
// with local misalignment rejection and a saturating contention counter.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic              dm_err_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  output logic              stall_f_o,
  output logic              stall_m_o,
  output logic [CNT_W-1:0]  conflict_cnt_o
);

  arb_state_t        state_r;
  arb_state_t        state_s;
  arb_owner_t        owner_r;
  logic              mem_req_r;
  logic              port_we_r;
  logic [ADDR_W-1:0] port_addr_r;
  logic [DATA_W-1:0] port_wdata_r;
  logic [DATA_W-1:0] if_rdata_r;
  logic [DATA_W-1:0] dm_rdata_r;
  logic              if_ack_r;
  logic              dm_ack_r;
  logic              dm_err_r;
  logic [CNT_W-1:0]  cnt_r;

  logic              dm_elig_s;
  logic              if_elig_s;
  logic              grant_d_s;
  logic              grant_i_s;
  logic              misal_s;
  logic              cap_i_s;
  logic              cap_d_s;
  logic              cnt_inc_s;

  assign dm_elig_s = dm_req_i & ~dm_ack_r;
  assign if_elig_s = if_req_i & ~if_ack_r;
  assign cap_i_s   = (state_r == BUSY_I) & mem_ready_i;
  assign cap_d_s   = (state_r == BUSY_D) & mem_ready_i;

  // Grant decision and next-state logic; data wins whenever both are eligible.
  always_comb begin
    state_s   = state_r;
    grant_d_s = 1'b0;
    grant_i_s = 1'b0;
    misal_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (dm_elig_s) begin
          grant_d_s = 1'b1;
          if (word_misaligned(dm_addr_i[1:0])) begin
            misal_s = 1'b1;
            state_s = DONE;
          end else begin
            misal_s = 1'b0;
            state_s = BUSY_D;
          end
        end else if (if_elig_s) begin
          grant_i_s = 1'b1;
          state_s   = BUSY_I;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready_i) begin
          state_s = DONE;
        end else begin
          state_s = state_r;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Fetch is held off while data owns the port or is being granted it.
  always_comb begin
    cnt_inc_s = 1'b0;
    if (if_req_i) begin
      cnt_inc_s = grant_d_s | (state_r == BUSY_D) |
                  ((state_r == DONE) & (owner_r == OWN_D));
    end else begin
      cnt_inc_s = 1'b0;
    end
  end

  // State, port registers, completion registers and contention counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= IDLE;
      owner_r      <= OWN_I;
      mem_req_r    <= 1'b0;
      port_we_r    <= 1'b0;
      port_addr_r  <= {ADDR_W{1'b0}};
      port_wdata_r <= {DATA_W{1'b0}};
      if_rdata_r   <= {DATA_W{1'b0}};
      dm_rdata_r   <= {DATA_W{1'b0}};
      if_ack_r     <= 1'b0;
      dm_ack_r     <= 1'b0;
      dm_err_r     <= 1'b0;
      cnt_r        <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_s;
      mem_req_r <= (state_s == BUSY_I) | (state_s == BUSY_D);
      if (grant_d_s) begin
        owner_r <= OWN_D;
      end else if (grant_i_s) begin
        owner_r <= OWN_I;
      end
      if (grant_d_s && !misal_s) begin
        port_we_r    <= dm_we_i;
        port_addr_r  <= dm_addr_i;
        port_wdata_r <= dm_wdata_i;
      end else if (grant_i_s) begin
        port_we_r   <= 1'b0;
        port_addr_r <= if_addr_i;
      end
      if (cap_i_s) begin
        if_rdata_r <= mem_rdata_i;
      end
      if (cap_d_s && !port_we_r) begin
        dm_rdata_r <= mem_rdata_i;
      end
      if_ack_r <= cap_i_s;
      dm_ack_r <= cap_d_s | misal_s;
      dm_err_r <= misal_s;
      if (cnt_inc_s && (cnt_r != {CNT_W{1'b1}})) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign if_ack_o       = if_ack_r;
  assign if_rdata_o     = if_rdata_r;
  assign dm_ack_o       = dm_ack_r;
  assign dm_err_o       = dm_err_r;
  assign dm_rdata_o     = dm_rdata_r;
  assign mem_req_o      = mem_req_r;
  assign mem_we_o       = port_we_r;
  assign mem_addr_o     = port_addr_r;
  assign mem_wdata_o    = port_wdata_r;
  assign conflict_cnt_o = cnt_r;
  assign stall_f_o      = if_req_i & ~if_ack_r;
  assign stall_m_o      = dm_req_i & ~dm_ack_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected completions are queued at
// request time and popped when the matching ack appears.
module tb_mem_port_arbiter;

  typedef struct {
    logic        is_d;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic        dm_ack_o;
  logic        dm_err_o;
  logic [31:0] dm_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ready_i;
  logic        stall_f_o;
  logic        stall_m_o;
  logic [15:0] conflict_cnt_o;

  logic        mem_ready_m;
  logic        force_ready;
  logic        mem_en;
  int          mem_wait;
  logic [31:0] mem_arr [logic [31:0]];

  exp_t        exp_q[$];
  logic [15:0] exp_cnt;
  int          checks;
  int          failures;

  assign mem_ready_i = mem_ready_m | force_ready;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_ack_o(dm_ack_o), .dm_err_o(dm_err_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
    .stall_f_o(stall_f_o), .stall_m_o(stall_m_o), .conflict_cnt_o(conflict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory model: answers after mem_wait cycles, garbage on the bus otherwise.
  initial begin
    int waited;
    waited      = 0;
    mem_ready_m = 1'b0;
    mem_rdata_i = 32'h0;
    forever begin
      @(negedge clk_i);
      if (mem_en && mem_req_o === 1'b1 && !mem_ready_m) begin
        if (waited >= mem_wait) begin
          mem_ready_m = 1'b1;
          mem_rdata_i = mem_arr.exists(mem_addr_o) ? mem_arr[mem_addr_o] : 32'h0;
          if (mem_we_o) mem_arr[mem_addr_o] = mem_wdata_o;
          waited = 0;
        end else begin
          waited++;
          mem_rdata_i = 32'hBAD0_0000 | 32'($urandom_range(0, 65535));
        end
      end else begin
        mem_ready_m = 1'b0;
        waited      = 0;
        mem_rdata_i = 32'hBAD0_0000 | 32'($urandom_range(0, 65535));
      end
    end
  end

  task automatic wait_ack(input int max_cyc, output int cyc, output logic got);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < max_cyc) begin
      @(negedge clk_i);
      cyc++;
      if (if_ack_o === 1'b1 || dm_ack_o === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({if_ack_o, if_rdata_o, dm_ack_o, dm_err_o, dm_rdata_o, mem_req_o, mem_we_o, mem_addr_o,
         mem_wdata_o, stall_f_o, stall_m_o, conflict_cnt_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: mem_req=%b acks=%b%b cnt=%h rdata=%h/%h, required all zero",
               mem_req_o, if_ack_o, dm_ack_o, conflict_cnt_o, if_rdata_o, dm_rdata_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  task automatic test_single_fetch();
    exp_t e;
    mem_arr[32'h100] = 32'h00500093;
    @(posedge clk_i); #1;
    if_req_i  = 1'b1;
    if_addr_i = 32'h100;
    exp_q.push_back('{1'b0, 1'b0, 32'h00500093});
    @(negedge clk_i);
    checks++;
    if (stall_f_o !== 1'b1 || mem_req_o !== 1'b0) begin
      failures++;
      $display("FAIL fetch_t: stall_f=%b mem_req=%b, required 1 0", stall_f_o, mem_req_o);
    end
    @(negedge clk_i);
    checks++;
    if ({mem_req_o, mem_we_o, mem_addr_o} !== {1'b1, 1'b0, 32'h100} || stall_f_o !== 1'b1 || if_ack_o !== 1'b0) begin
      failures++;
      $display("FAIL fetch_t1: mem_req=%b we=%b addr=%h stall_f=%b ack=%b, required 1 0 100 1 0",
               mem_req_o, mem_we_o, mem_addr_o, stall_f_o, if_ack_o);
    end
    @(negedge clk_i);
    checks++;
    if (if_ack_o !== 1'b1 || dm_ack_o !== 1'b0 || stall_f_o !== 1'b0 || exp_q.size() == 0) begin
      failures++;
      $display("FAIL fetch_ack: if_ack=%b dm_ack=%b stall_f=%b pending=%0d, required 1 0 0 1",
               if_ack_o, dm_ack_o, stall_f_o, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (e.is_d !== 1'b0 || if_rdata_o !== e.rdata) begin
        failures++;
        $display("FAIL fetch_rdata: got %h, required %h", if_rdata_o, e.rdata);
      end
    end
    @(posedge clk_i); #1;
    if_req_i = 1'b0;
  endtask

  task automatic test_simultaneous();
    exp_t e;
    int   cyc;
    logic got;
    mem_arr[32'h2000] = 32'h11223344;
    mem_arr[32'h104]  = 32'h00A00113;
    @(posedge clk_i); #1;
    if_req_i  = 1'b1;
    if_addr_i = 32'h104;
    dm_req_i  = 1'b1;
    dm_we_i   = 1'b0;
    dm_addr_i = 32'h2000;
    exp_q.push_back('{1'b1, 1'b0, 32'h11223344});
    exp_q.push_back('{1'b0, 1'b0, 32'h00A00113});
    wait_ack(10, cyc, got);
    checks++;
    if (!got || cyc != 3 || dm_ack_o !== 1'b1 || if_ack_o !== 1'b0) begin
      failures++;
      $display("FAIL simul_first: got=%b cyc=%0d dm_ack=%b if_ack=%b, required 1 3 1 0",
               got, cyc, dm_ack_o, if_ack_o);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (e.is_d !== 1'b1 || dm_rdata_o !== e.rdata || dm_err_o !== 1'b0) begin
        failures++;
        $display("FAIL simul_load: dm_rdata=%h err=%b, required %h 0", dm_rdata_o, dm_err_o, e.rdata);
      end
    end
    @(posedge clk_i); #1;
    dm_req_i = 1'b0;
    exp_cnt  = exp_cnt + 16'd3;
    @(negedge clk_i);
    checks++;
    if (mem_req_o !== 1'b0 || conflict_cnt_o !== exp_cnt || stall_f_o !== 1'b1) begin
      failures++;
      $display("FAIL simul_idle: mem_req=%b cnt=%0d stall_f=%b, required 0 %0d 1",
               mem_req_o, conflict_cnt_o, stall_f_o, exp_cnt);
    end
    wait_ack(10, cyc, got);
    checks++;
    if (!got || cyc != 2 || if_ack_o !== 1'b1 || exp_q.size() == 0) begin
      failures++;
      $display("FAIL simul_second: got=%b cyc=%0d if_ack=%b, required 1 2 1", got, cyc, if_ack_o);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (e.is_d !== 1'b0 || if_rdata_o !== e.rdata || conflict_cnt_o !== exp_cnt) begin
        failures++;
        $display("FAIL simul_fetch: if_rdata=%h cnt=%0d, required %h %0d",
                 if_rdata_o, conflict_cnt_o, e.rdata, exp_cnt);
      end
    end
    @(posedge clk_i); #1;
    if_req_i = 1'b0;
  endtask

  task automatic test_store_wait();
    exp_t e;
    mem_wait = 2;
    @(posedge clk_i); #1;
    dm_req_i   = 1'b1;
    dm_we_i    = 1'b1;
    dm_addr_i  = 32'h2004;
    dm_wdata_i = 32'hDEADBEEF;
    exp_q.push_back('{1'b1, 1'b0, 32'h11223344});
    @(negedge clk_i);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_i);
      checks++;
      if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 1'b1, 32'h2004, 32'hDEADBEEF} ||
          dm_ack_o !== 1'b0) begin
        failures++;
        $display("FAIL store_hold%0d: req=%b we=%b addr=%h wdata=%h ack=%b, required 1 1 2004 deadbeef 0",
                 k, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, dm_ack_o);
      end
      dm_addr_i  = 32'h3000;
      dm_wdata_i = 32'h0;
    end
    @(negedge clk_i);
    checks++;
    if (dm_ack_o !== 1'b1 || dm_err_o !== 1'b0 || mem_req_o !== 1'b0 || exp_q.size() == 0) begin
      failures++;
      $display("FAIL store_ack: ack=%b err=%b mem_req=%b, required 1 0 0", dm_ack_o, dm_err_o, mem_req_o);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (dm_rdata_o !== e.rdata) begin
        failures++;
        $display("FAIL store_rdata: dm_rdata=%h, required unchanged %h", dm_rdata_o, e.rdata);
      end
    end
    @(posedge clk_i); #1;
    dm_req_i = 1'b0;
    dm_we_i  = 1'b0;
    mem_wait = 0;
  endtask

  task automatic test_misaligned();
    exp_t e;
    @(posedge clk_i); #1;
    dm_req_i  = 1'b1;
    dm_we_i   = 1'b0;
    dm_addr_i = 32'h2002;
    exp_q.push_back('{1'b1, 1'b1, 32'h0});
    @(negedge clk_i);
    checks++;
    if (stall_m_o !== 1'b1 || mem_req_o !== 1'b0 || dm_ack_o !== 1'b0) begin
      failures++;
      $display("FAIL misal_t: stall_m=%b mem_req=%b ack=%b, required 1 0 0", stall_m_o, mem_req_o, dm_ack_o);
    end
    @(negedge clk_i);
    checks++;
    if (dm_ack_o !== 1'b1 || mem_req_o !== 1'b0 || stall_m_o !== 1'b0 || exp_q.size() == 0) begin
      failures++;
      $display("FAIL misal_ack: ack=%b mem_req=%b stall_m=%b, required 1 0 0", dm_ack_o, mem_req_o, stall_m_o);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (dm_err_o !== e.err || e.is_d !== 1'b1) begin
        failures++;
        $display("FAIL misal_err: err=%b, required %b", dm_err_o, e.err);
      end
    end
    @(posedge clk_i); #1;
    dm_req_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({dm_ack_o, dm_err_o, mem_req_o} !== 3'b000) begin
      failures++;
      $display("FAIL misal_pulse: ack=%b err=%b mem_req=%b, required 0 0 0", dm_ack_o, dm_err_o, mem_req_o);
    end
  endtask

  task automatic test_ready_idle();
    @(posedge clk_i); #1;
    force_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      checks++;
      if ({if_ack_o, dm_ack_o, mem_req_o} !== 3'b000 || if_rdata_o !== 32'h00A00113 ||
          dm_rdata_o !== 32'h11223344) begin
        failures++;
        $display("FAIL ready_idle%0d: acks=%b%b mem_req=%b if_rdata=%h dm_rdata=%h, required 0 0 0 00a00113 11223344",
                 k, if_ack_o, dm_ack_o, mem_req_o, if_rdata_o, dm_rdata_o);
      end
    end
    @(posedge clk_i); #1;
    force_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    mem_en = 1'b0;
    @(posedge clk_i); #1;
    dm_req_i  = 1'b1;
    dm_we_i   = 1'b0;
    dm_addr_i = 32'h2008;
    repeat (3) @(negedge clk_i);
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h2008) begin
      failures++;
      $display("FAIL rstmid_busy: mem_req=%b addr=%h, required 1 2008", mem_req_o, mem_addr_o);
    end
    @(posedge clk_i); #1;
    rst_i    = 1'b1;
    dm_req_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({if_ack_o, if_rdata_o, dm_ack_o, dm_err_o, dm_rdata_o, mem_req_o, mem_we_o, mem_addr_o,
         mem_wdata_o, stall_f_o, stall_m_o, conflict_cnt_o} !== '0) begin
      failures++;
      $display("FAIL rstmid_zero: mem_req=%b addr=%h cnt=%0d rdata=%h/%h, required all zero",
               mem_req_o, mem_addr_o, conflict_cnt_o, if_rdata_o, dm_rdata_o);
    end
    exp_cnt = 16'd0;
    @(posedge clk_i); #1;
    rst_i       = 1'b0;
    force_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      checks++;
      if ({if_ack_o, dm_ack_o, mem_req_o} !== 3'b000) begin
        failures++;
        $display("FAIL rstmid_late%0d: acks=%b%b mem_req=%b, required 0 0 0", k, if_ack_o, dm_ack_o, mem_req_o);
      end
      force_ready = 1'b0;
    end
    mem_en = 1'b1;
  endtask

  task automatic test_saturation();
    @(posedge clk_i); #1;
    if_req_i  = 1'b1;
    if_addr_i = 32'h100;
    dm_req_i  = 1'b1;
    dm_we_i   = 1'b0;
    dm_addr_i = 32'h2002;
    repeat (100) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (conflict_cnt_o !== 16'd100 || if_ack_o !== 1'b0) begin
      failures++;
      $display("FAIL sat_count100: cnt=%0d if_ack=%b, required 100 0", conflict_cnt_o, if_ack_o);
    end
    repeat (65434) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (conflict_cnt_o !== 16'hFFFE) begin
      failures++;
      $display("FAIL sat_near: cnt=%h, required fffe", conflict_cnt_o);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (conflict_cnt_o !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_max: cnt=%h, required ffff", conflict_cnt_o);
    end
    repeat (20) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (conflict_cnt_o !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_hold: cnt=%h, required ffff (no wrap)", conflict_cnt_o);
    end
    @(posedge clk_i); #1;
    if_req_i = 1'b0;
    dm_req_i = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    exp_cnt     = 16'd0;
    mem_en      = 1'b1;
    mem_wait    = 0;
    force_ready = 1'b0;
    rst_i       = 1'b1;
    if_req_i    = 1'b0;
    if_addr_i   = 32'h0;
    dm_req_i    = 1'b0;
    dm_we_i     = 1'b0;
    dm_addr_i   = 32'h0;
    dm_wdata_i  = 32'h0;

    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_store_wait();
    test_misaligned();
    test_ready_idle();
    test_reset_mid();
    test_saturation();

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d completions never observed, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
